mem_store_rmw: RTL and testbench
================================

MEM_STORE_RMW -- requirements
Module: mem_store_rmw

Interface
REQ-001 Parameter AW, default 32, data-memory byte-address width.
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 rst_n  in  1  reset, asynchronous, active-low.
REQ-004 req  in  1  store request; sampled only while ready=1.
REQ-005 addr  in  AW  store byte address.
REQ-006 wdata  in  32  store data; operand right-aligned (byte in [7:0], half in [15:0]).
REQ-007 full, half, byte  in  1 each  size selects; priority full > half > byte.
REQ-008 ready  out  1  high only in IDLE; unit accepts a request.
REQ-009 done  out  1  one-cycle pulse when a store completes or is rejected.
REQ-010 err  out  1  one-cycle pulse, coincident with done, on misaligned or sizeless request.
REQ-011 dm_addr  out  AW  word address to data memory, {addr[AW-1:2],2'b00}.
REQ-012 dm_re  out  1  memory read strobe; dm_rdata valid the following cycle.
REQ-013 dm_rdata  in  32  memory read data.
REQ-014 dm_we  out  1  memory write strobe, full-word write.
REQ-015 dm_wdata  out  32  memory write data.

Function
REQ-016 States: IDLE, READ, MERGE, WRITE, ERR; outputs registered or decoded from state only.
REQ-017 IDLE with req=1 latches addr, wdata, size into internal registers; req with ready=0 is ignored.
REQ-018 Accepted full store: IDLE -> WRITE; dm_we=1, dm_wdata=latched wdata; addr[1:0] ignored.
REQ-019 Accepted half store, addr[1:0] in {00,10}: IDLE -> READ -> MERGE -> WRITE.
REQ-020 Accepted byte store, any addr[1:0]: IDLE -> READ -> MERGE -> WRITE.
REQ-021 READ: dm_re=1, dm_addr=word address; dm_we=0.
REQ-022 MERGE: registers dm_rdata with target lane replaced; dm_re=0, dm_we=0.
REQ-023 Half lanes: addr[1:0]=00 -> bits [15:0]; 10 -> bits [31:16]; other bits preserved from dm_rdata.
REQ-024 Byte lanes: addr[1:0]=00 -> [7:0], 01 -> [15:8], 10 -> [23:16], 11 -> [31:24]; other bits preserved.
REQ-025 WRITE: dm_we=1 for exactly one cycle, done=1 same cycle, then IDLE.
REQ-026 Latency from accept edge to dm_we: full 1 cycle, partial 3 cycles.
REQ-027 Half store with addr[1:0] in {01,11}, or no size select asserted: IDLE -> ERR; ERR pulses done=1, err=1; dm_re=0, dm_we=0; then IDLE.
REQ-028 ready=0 in every state except IDLE; earliest next accept is the cycle after done.
REQ-029 Changes on addr/wdata/size after accept do not affect the in-flight store.
REQ-030 dm_wdata and dm_addr hold last driven values when dm_we=0; memory ignores them.

Reset
REQ-031 rst_n=0 forces state IDLE immediately, without waiting for a clock edge.
REQ-032 Reset values: ready=1, done=0, err=0, dm_re=0, dm_we=0, dm_addr=0, dm_wdata=0, internal latches 0.
REQ-033 Reset during READ/MERGE/WRITE aborts the store; no dm_we is issued after rst_n falls.

Structure
REQ-034 Shared package mem_pkg holds state encoding, lane index constants, size-select priority helpers; load path and store path both use it.
REQ-035 One combinational sub-module, store_merge (inputs old word, new data, addr[1:0], size; output merged word), instantiated in MERGE datapath.
REQ-036 Target 120-400 RTL lines total.

Verification
REQ-037 full, addr=0x104, wdata=0xDEADBEEF -> next cycle dm_we=1, dm_addr=0x104, dm_wdata=0xDEADBEEF, done=1, no dm_re.
REQ-038 byte, addr=0x203, wdata=0x000000AB, dm_rdata=0x11223344 -> dm_re cycle 1; cycle 3 dm_we=1, dm_wdata=0xAB223344.
REQ-039 half, addr=0x302, wdata=0x0000CAFE, dm_rdata=0x11223344 -> cycle 3 dm_wdata=0xCAFE3344; half addr=0x300 -> 0x1122CAFE.
REQ-040 half, addr=0x301 -> cycle 1 done=1, err=1; dm_re and dm_we never asserted; ready=1 cycle 2.
REQ-041 req held high across back-to-back byte stores -> second accepted only after done; both writes correct, ready low throughout each.
REQ-042 rst_n low during MERGE -> state IDLE and ready=1 asynchronously; no dm_we pulse for aborted store.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared definitions for the data-memory load/store units: FSM encoding,
// lane offsets and access-size decoding helpers.
package mem_pkg;

    // Store FSM encoding
    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRead  = 3'd1;
    localparam logic [2:0] StMerge = 3'd2;
    localparam logic [2:0] StWrite = 3'd3;
    localparam logic [2:0] StErr   = 3'd4;

    // Access size after priority resolution
    typedef enum logic [1:0] {
        SzNone = 2'd0,
        SzByte = 2'd1,
        SzHalf = 2'd2,
        SzFull = 2'd3
    } size_e;

    // Least-significant bit of each lane inside a 32-bit word
    localparam int unsigned HalfLoLsb = 0;
    localparam int unsigned HalfHiLsb = 16;
    localparam int unsigned ByteWidth = 8;

    // Full beats half beats byte; nothing selected means no size.
    function automatic size_e size_sel(input logic sel_full, input logic sel_half,
                                       input logic sel_byte);
        if (sel_full) begin
            return SzFull;
        end else if (sel_half) begin
            return SzHalf;
        end else if (sel_byte) begin
            return SzByte;
        end
        return SzNone;
    endfunction

    // A request that can never be performed: no size, or a half on an odd byte.
    function automatic logic access_bad(input size_e sz, input logic [1:0] lo);
        return (sz == SzNone) || ((sz == SzHalf) && lo[0]);
    endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge: replaces the addressed byte/half of an old word
// with right-aligned new data; a full store passes the new data through.
module store_merge
    import mem_pkg::*;
(
    input  logic [31:0] old_word_i,
    input  logic [31:0] new_data_i,
    input  logic [1:0]  lane_i,
    input  size_e       size_i,
    output logic [31:0] merged_o
);

    // Start from the old word and overwrite only the target lane
    always_comb begin
        merged_o = old_word_i;
        case (size_i)
            SzFull: merged_o = new_data_i;
            SzHalf: begin
                if (lane_i[1]) begin
                    merged_o[HalfHiLsb +: 16] = new_data_i[15:0];
                end else begin
                    merged_o[HalfLoLsb +: 16] = new_data_i[15:0];
                end
            end
            SzByte: merged_o[{lane_i, 3'b000} +: ByteWidth] = new_data_i[7:0];
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_store_rmw.sv
// Store unit for a word-wide data memory. Full-word stores are written
// directly; byte/half stores read the word, merge the lane and write it back.
// Misaligned or sizeless requests are rejected with a done+err pulse.
module mem_store_rmw
    import mem_pkg::*;
#(
    parameter int unsigned AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          req_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    input  logic          full_i,
    input  logic          half_i,
    input  logic          byte_i,
    output logic          ready_o,
    output logic          done_o,
    output logic          err_o,
    output logic [AW-1:0] dm_addr_o,
    output logic          dm_re_o,
    input  logic [31:0]   dm_rdata_i,
    output logic          dm_we_o,
    output logic [31:0]   dm_wdata_o
);

    logic [2:0]    state_q, state_d;
    logic [1:0]    addr_lo_q;
    logic [31:0]   wdata_q;
    size_e         size_q;
    logic [AW-1:0] dm_addr_q;
    logic [31:0]   dm_wdata_q;

    size_e         req_size;
    logic          req_bad;
    logic          accept;
    logic [31:0]   merged;

    assign req_size = size_sel(full_i, half_i, byte_i);
    assign req_bad  = access_bad(req_size, addr_i[1:0]);
    assign accept   = (state_q == StIdle) && req_i;

    // Next-state: full goes straight to write, partials read-modify-write
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (req_i) begin
                    if (req_bad) begin
                        state_d = StErr;
                    end else if (req_size == SzFull) begin
                        state_d = StWrite;
                    end else begin
                        state_d = StRead;
                    end
                end
            end
            StRead:  state_d = StMerge;
            StMerge: state_d = StWrite;
            StWrite: state_d = StIdle;
            StErr:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State register; reset aborts any store in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the request at accept so later input changes cannot leak in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_lo_q <= 2'b00;
            wdata_q   <= 32'h0;
            size_q    <= SzNone;
        end else if (accept) begin
            addr_lo_q <= addr_i[1:0];
            wdata_q   <= wdata_i;
            size_q    <= req_size;
        end
    end

    store_merge u_store_merge (
        .old_word_i (dm_rdata_i),
        .new_data_i (wdata_q),
        .lane_i     (addr_lo_q),
        .size_i     (size_q),
        .merged_o   (merged)
    );

    // Memory-side address/data; held between writes, rejected requests leave them alone
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dm_addr_q  <= '0;
            dm_wdata_q <= 32'h0;
        end else if (accept && !req_bad) begin
            dm_addr_q <= {addr_i[AW-1:2], 2'b00};
            if (req_size == SzFull) begin
                dm_wdata_q <= wdata_i;
            end
        end else if (state_q == StMerge) begin
            // dm_rdata_i is valid this cycle, one cycle after the read strobe
            dm_wdata_q <= merged;
        end
    end

    assign ready_o    = (state_q == StIdle);
    assign dm_re_o    = (state_q == StRead);
    assign dm_we_o    = (state_q == StWrite);
    assign done_o     = (state_q == StWrite) || (state_q == StErr);
    assign err_o      = (state_q == StErr);
    assign dm_addr_o  = dm_addr_q;
    assign dm_wdata_o = dm_wdata_q;

endmodule

// File: tb/tb_mem_store_rmw.sv
// Scoreboard bench for mem_store_rmw: the driver pushes the expected outcome
// of each request, a monitor pops and compares on every done pulse.
module tb_mem_store_rmw;

    localparam int unsigned AW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          req_i = 1'b0;
    logic [AW-1:0] addr_i = '0;
    logic [31:0]   wdata_i = 32'h0;
    logic          full_i = 1'b0;
    logic          half_i = 1'b0;
    logic          byte_i = 1'b0;
    logic          ready_o, done_o, err_o, dm_re_o, dm_we_o;
    logic [AW-1:0] dm_addr_o;
    logic [31:0]   dm_rdata_i = 32'h0;
    logic [31:0]   dm_wdata_o;

    mem_store_rmw #(.AW(AW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_i      (req_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .full_i     (full_i),
        .half_i     (half_i),
        .byte_i     (byte_i),
        .ready_o    (ready_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .dm_addr_o  (dm_addr_o),
        .dm_re_o    (dm_re_o),
        .dm_rdata_i (dm_rdata_i),
        .dm_we_o    (dm_we_o),
        .dm_wdata_o (dm_wdata_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_err;
        logic        partial;
        logic [31:0] waddr;
        logic [31:0] data;
        int unsigned cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] bus_mem   [1024];
    logic [31:0] model_mem [1024];
    int unsigned cyc = 0;
    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    logic        prev_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory seen by the DUT: one-cycle read latency, full-word writes
    always @(posedge clk) begin
        if (dm_we_o) bus_mem[dm_addr_o[11:2]] <= dm_wdata_o;
        if (dm_re_o) dm_rdata_i <= bus_mem[dm_addr_o[11:2]];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: what a store must write, from size priority and lane arithmetic
    function automatic exp_t model(input logic f, input logic h, input logic b,
                                   input logic [31:0] a, input logic [31:0] w,
                                   input int unsigned c);
        exp_t        e;
        logic [31:0] old;
        logic [31:0] mask;
        int unsigned sh;
        e.waddr   = a & ~32'h3;
        old       = model_mem[a[11:2]];
        e.is_err  = 1'b0;
        e.partial = 1'b1;
        e.data    = old;
        if (f) begin
            e.partial = 1'b0;
            e.data    = w;
        end else if (h) begin
            if (a[0]) begin
                e.is_err = 1'b1;
            end else begin
                sh     = a[1] ? 16 : 0;
                mask   = 32'hFFFF << sh;
                e.data = (old & ~mask) | ((w & 32'hFFFF) << sh);
            end
        end else if (b) begin
            sh     = 8 * int'(a[1:0]);
            mask   = 32'hFF << sh;
            e.data = (old & ~mask) | ((w & 32'hFF) << sh);
        end else begin
            e.is_err = 1'b1;
        end
        if (e.is_err) e.partial = 1'b0;
        e.cyc = c + (e.partial ? 3 : 1);
        return e;
    endfunction

    task automatic finish_run();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    endtask

    // Returns at a falling edge with ready high
    task automatic wait_ready();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (ready_o) return;
        end
        n_chk++;
        $display("FAIL ready_timeout: ready stayed 0 for 50 cycles");
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "ready timeout");
    endtask

    task automatic drive(input logic f, input logic h, input logic b,
                         input logic [31:0] a, input logic [31:0] w);
        full_i  = f;
        half_i  = h;
        byte_i  = b;
        addr_i  = a;
        wdata_i = w;
        req_i   = 1'b1;
    endtask

    task automatic scramble();
        addr_i  = $urandom;
        wdata_i = $urandom;
        full_i  = 1'($urandom);
        half_i  = 1'($urandom);
        byte_i  = 1'($urandom);
    endtask

    task automatic issue(input logic f, input logic h, input logic b,
                         input logic [31:0] a, input logic [31:0] w);
        wait_ready();
        drive(f, h, b, a, w);
        sb.push_back(model(f, h, b, a, w, cyc));
        @(posedge clk);
        #1;
        req_i = 1'b0;
        scramble();
    endtask

    task automatic drain();
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0) return;
            @(negedge clk);
        end
        check("drain_pending", sb.size(), 0);
        sb.delete();
    endtask

    task automatic preset(input logic [31:0] a, input logic [31:0] v);
        bus_mem[a[11:2]]   = v;
        model_mem[a[11:2]] = v;
    endtask

    // Monitor: compare every read strobe and done pulse against the queue head
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_done = 1'b0;
        end else begin
            if (prev_done) check("ready_after_done", ready_o, 1);
            prev_done = done_o;
            if (dm_re_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_read", dm_re_o, 0);
                end else begin
                    check("read_partial", sb[0].partial, 1);
                    check("read_addr", dm_addr_o, sb[0].waddr);
                    check("read_cyc", cyc, sb[0].cyc - 2);
                    check("read_we_ready", {dm_we_o, ready_o}, 0);
                end
            end
            if (done_o) begin
                if (sb.size() == 0) begin
                    check("unexpected_done", done_o, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("done_err", err_o, e.is_err);
                    check("done_we", dm_we_o, !e.is_err);
                    check("done_cyc", cyc, e.cyc);
                    check("done_ready", ready_o, 0);
                    if (!e.is_err) begin
                        check("write_addr", dm_addr_o, e.waddr);
                        check("write_data", dm_wdata_o, e.data);
                        model_mem[e.waddr[11:2]] = e.data;
                    end
                end
            end else begin
                check("stray_err_we", {err_o, dm_we_o}, 0);
            end
        end
    end

    initial begin
        logic [2:0]  sz;
        logic [31:0] a;
        exp_t        ea;
        for (int i = 0; i < 1024; i++) preset(i * 4, (i * 32'h9E3779B1) ^ 32'h5A5A1234);
        preset(32'h200, 32'h11223344);
        preset(32'h300, 32'h11223344);

        // Reset values are visible before any clock edge
        #3;
        check("rst_ready", ready_o, 1);
        check("rst_done_err", {done_o, err_o}, 0);
        check("rst_re_we", {dm_re_o, dm_we_o}, 0);
        check("rst_dm_addr", dm_addr_o, 0);
        check("rst_dm_wdata", dm_wdata_o, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        issue(1, 0, 0, 32'h104, 32'hDEADBEEF);
        issue(0, 0, 1, 32'h203, 32'h000000AB);
        issue(0, 1, 0, 32'h302, 32'h0000CAFE);
        drain();
        preset(32'h300, 32'h11223344);
        issue(0, 1, 0, 32'h300, 32'h0000CAFE);
        issue(0, 1, 0, 32'h301, 32'h0000BEEF);
        issue(0, 0, 0, 32'h308, 32'h12345678);
        issue(1, 1, 1, 32'h30B, 32'hA5A5A5A5);
        issue(0, 1, 1, 32'h30C, 32'h00001234);
        drain();

        // Back-to-back byte stores with req held high
        wait_ready();
        drive(0, 0, 1, 32'h501, 32'h0000003C);
        ea = model(0, 0, 1, 32'h501, 32'h3C, cyc);
        sb.push_back(ea);
        @(posedge clk);
        #1;
        drive(0, 0, 1, 32'h507, 32'h000000C3);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_busy_a", ready_o, 0);
        end
        wait_ready();
        check("b2b_gap", cyc, ea.cyc + 1);
        sb.push_back(model(0, 0, 1, 32'h507, 32'hC3, cyc));
        @(posedge clk);
        #1;
        req_i = 1'b0;
        scramble();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("b2b_busy_b", ready_o, 0);
        end
        drain();

        // Asynchronous reset in MERGE aborts the store
        issue(0, 0, 1, 32'h602, 32'h00000077);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_ready", ready_o, 1);
        check("arst_we_re_done", {dm_we_o, dm_re_o, done_o}, 0);
        sb.delete();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        check("arst_mem_kept", bus_mem[32'h600 >> 2], model_mem[32'h600 >> 2]);

        // Randomised traffic over a small window so words get reused
        for (int n = 0; n < 80; n++) begin
            sz = 3'($urandom);
            a  = 32'h400 | ($urandom & 32'h3F);
            issue(sz[2], sz[1], sz[0], a, $urandom);
        end
        drain();
        for (int i = 256; i < 272; i++) check("final_mem", bus_mem[i], model_mem[i]);
        finish_run();
    end

endmodule
